// File: rtl/rr_stream_mux.sv
// Registered N-channel stream multiplexer. Selects one valid/ready input per cycle,
// either by address or by round-robin, into a one-entry output register with backpressure.
module rr_stream_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          address,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_channel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_p0;
  logic             grant_vld_p0;
  logic [SEL_W-1:0] scan_idx;
  logic             space;
  logic             accept;

  // Stage p0: combinational grant from mode/address/in_valid/rr_ptr.
  always_comb begin
    grant_p0     = '0;
    grant_vld_p0 = 1'b0;
    scan_idx     = '0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (SEL_W'(i) == address && in_valid[i]) begin
          grant_p0     = SEL_W'(i);
          grant_vld_p0 = 1'b1;
        end
      end
    end else begin
      // Descending scan so the channel nearest after rr_ptr is written last and wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        scan_idx = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
        if (in_valid[scan_idx]) begin
          grant_p0     = scan_idx;
          grant_vld_p0 = 1'b1;
        end
      end
    end
  end

  assign space     = (state == EMPTY) || out_ready;
  assign accept    = grant_vld_p0 && space;
  assign out_valid = (state == FULL);

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant_p0] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (accept)         state_nxt = FULL;
    else if (out_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Stage p1: output register and arbitration pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= '0;
      out_channel <= '0;
      rr_ptr      <= SEL_W'(CHANNELS - 1);
    end else if (accept) begin
      out_data    <= in_data[grant_p0*WIDTH +: WIDTH];
      out_channel <= grant_p0;
      rr_ptr      <= grant_p0;
    end
  end

endmodule
